// File: rtl/spi_packet_master.sv
// spi_packet_master: packet source for the router SPI link.
// Captures an 8-bit destination and data word on start, appends the 9-bit
// checksum (dest + data, carry kept), and shifts the 25-bit packet MSB-first
// onto masterClock/bitOut/selectOut with a fixed divided serial clock.
// Optional feature macro: SPI_FAULT_INJECT_EN adds input corruptChecksum,
// which inverts the transmitted checksum LSB when set with start.
module spi_packet_master #(
    parameter int CLK_DIV = 4,
    parameter int SIZE    = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
`ifdef SPI_FAULT_INJECT_EN
    input  logic            corruptChecksum,
`endif
    input  logic [SIZE-1:0] destIn,
    input  logic [SIZE-1:0] dataIn,
    output logic            busy,
    output logic            done,
    output logic            masterClock,
    output logic            bitOut,
    output logic            selectOut
);

    localparam int PKT_W = 3 * SIZE + 1;
    localparam int CNT_W = $clog2(PKT_W);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LOW_END = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_BIT_END = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(PKT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [SIZE-1:0]   r_dest;
    logic [SIZE-1:0]   r_data;
    logic              r_corrupt;
    // Bits still waiting to be sent; the bit on the wire lives in r_bit_out.
    logic [PKT_W-2:0]  r_shift;
    logic [CNT_W-1:0]  r_bit;
    logic [DIV_W-1:0]  r_div;
    logic              r_busy;
    logic              r_done;
    logic              r_mclk;
    logic              r_bit_out;
    logic              r_select;

    logic [SIZE:0]     w_checksum;
    logic [PKT_W-1:0]  w_packet;

`ifdef SPI_FAULT_INJECT_EN
    logic              w_corrupt_in;
    assign w_corrupt_in = corruptChecksum;
`else
    logic              w_corrupt_in;
    assign w_corrupt_in = 1'b0;
`endif

    // Checksum keeps the carry in its top bit; the fault option flips its LSB.
    assign w_checksum = ({1'b0, r_dest} + {1'b0, r_data}) ^ {{SIZE{1'b0}}, r_corrupt};
    assign w_packet   = {r_dest, r_data, w_checksum};

    assign busy        = r_busy;
    assign done        = r_done;
    assign masterClock = r_mclk;
    assign bitOut      = r_bit_out;
    assign selectOut   = r_select;

    // Frame sequencer: every output is set for the state being entered, so
    // all link and handshake outputs come straight from flops.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_dest    <= '0;
            r_data    <= '0;
            r_corrupt <= 1'b0;
            r_shift   <= '0;
            r_bit     <= '0;
            r_div     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_mclk    <= 1'b0;
            r_bit_out <= 1'b0;
            r_select  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dest    <= destIn;
                        r_data    <= dataIn;
                        r_corrupt <= w_corrupt_in;
                        r_busy    <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_shift   <= w_packet[PKT_W-2:0];
                    r_bit     <= LAST_BIT;
                    r_div     <= '0;
                    r_bit_out <= w_packet[PKT_W-1];
                    r_mclk    <= 1'b0;
                    r_select  <= 1'b1;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_div == DIV_BIT_END) begin
                        // End of the high phase: next bit or end of frame.
                        r_div  <= '0;
                        r_mclk <= 1'b0;
                        if (r_bit == '0) begin
                            r_select <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_bit_out <= r_shift[PKT_W-2];
                            r_shift   <= {r_shift[PKT_W-3:0], 1'b0};
                            r_bit     <= r_bit - 1'b1;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                        if (r_div == DIV_LOW_END) begin
                            r_mclk <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_packet_master.md
# spi_packet_master

Upstream packet source for the router datapath: accepts an 8-bit destination and 8-bit data word, computes the 9-bit checksum, and serializes the 25-bit packet MSB-first onto the SPI link (`masterClock`, `bitOut`, `selectOut`) consumed by the datapath's SPI receiver. It is used both as the stimulus engine in system benches and as the on-chip sender in loopback builds. Start/busy/done handshake on the host side; fixed-rate divided serial clock on the link side.

## Interface
- `CLK_DIV`, default 4: `masterClock` half-period in `clock` cycles; legal range 1..255.
- `SIZE`, default 8: destination/data width; packet width = 3*SIZE+1.
- `clock` input 1: system clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-high; one clock, reset is asynchronous and active-high.
- `start` input 1: request to send; sampled only in IDLE.
- `destIn` input SIZE: destination byte, captured on accepted `start`.
- `dataIn` input SIZE: data byte, captured on accepted `start`.
- `busy` output 1: high from cycle after accepted `start` through DONE.
- `done` output 1: one-cycle pulse when the last bit has completed.
- `masterClock` output 1: serial clock, idle low.
- `bitOut` output 1: serial data, MSB first.
- `selectOut` output 1: frame enable, high for exactly the SHIFT state.

## Operation
- Packet = {dest[7:0], data[7:0], checksum[8:0]}, bit 24 sent first; checksum = dest + data, 9-bit unsigned, carry kept in bit 8.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: `start`=1 -> capture `destIn`/`dataIn`, go LOAD. Else stay.
- LOAD (1 cycle): form 25-bit shift register with checksum; bit counter = 24; divider counter = 0; go SHIFT.
- SHIFT: each bit occupies 2*CLK_DIV cycles: `masterClock` low for first CLK_DIV, high for next CLK_DIV. `bitOut` = current MSB, updated only at the start of a low phase; stable across the rising edge (receiver samples on rising `masterClock`). At end of high phase: shift left, decrement counter; after bit 0 high phase -> DONE.
- DONE (1 cycle): `done`=1, `masterClock`=0, `selectOut`=0; go IDLE.
- `start` outside IDLE is ignored (no queueing); `destIn`/`dataIn` may change freely after capture.
- All outputs registered (no combinational paths from inputs).

## Timing
- Reset values: `busy`=0, `done`=0, `masterClock`=0, `bitOut`=0, `selectOut`=0, FSM=IDLE, counters 0. Reset mid-frame aborts immediately (asynchronous), no `done` pulse; link returns idle.
- `start` high at edge N -> LOAD at N+1 (`busy`=1), SHIFT from N+2 for 50*CLK_DIV cycles, DONE pulse in the following cycle, `busy` low the cycle after DONE.
- Total frame latency start->done = 2 + 50*CLK_DIV cycles (202 at default).
- `start` held high continuously: next frame accepted in the IDLE cycle after DONE; minimum inter-frame gap of one IDLE cycle with `selectOut`=0.
- Exactly 25 rising `masterClock` edges per frame, all while `selectOut`=1.
- `bitOut` holds last sent bit (checksum[0]) after frame until next frame's first low phase; returns to 0 only on reset.

## Configuration
- `SPI_FAULT_INJECT_EN`: when defined, adds input `corruptChecksum` (1 bit, sampled with `start`); if set, checksum LSB is inverted in the transmitted packet, forcing `errorData` downstream. When undefined, the port does not exist and checksum is always correct.

## Test plan
- dest=0x80, data=0x05, CLK_DIV=4 -> serial stream 1000_0000 0000_0101 0_1000_0101 (checksum 0x085), done at start+202 cycles.
- dest=0xFF, data=0xFF -> checksum 0x1FE, last 9 bits 1_1111_1110.
- `start` pulsed at cycle 50 of an active frame -> ignored; exactly 25 rising edges, one `done`.
- `reset` asserted mid-SHIFT (bit 12) -> all outputs 0 same cycle, no `done`; new `start` after release sends full frame.
- CLK_DIV=1, `start` held high -> back-to-back frames 53 cycles apart, one IDLE gap with `selectOut`=0.
- With `SPI_FAULT_INJECT_EN`, dest=0x80, data=0x05, `corruptChecksum`=1 -> checksum field 0x084.
